// File: rtl/spi_master_sched.sv
// SPI mode-0 master that time-shares one bus between NUM_REQ requesters.
// Each grant carries one full-duplex DATA_W-bit frame, MSB first.
// SCLK half-period is CLK_DIV clk cycles.
// Round-robin arbitration by default. Defining SPI_MASTER_SCHED_FIXED_PRIO_EN
// switches to fixed priority (lowest index wins) and drops the pointer.
// Frame timing is the same in both builds.
module spi_master_sched #(
  parameter int unsigned NUM_REQ = 2,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CLK_DIV = 4,
  localparam int unsigned IdW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IdW-1:0]            rsp_id,
  output logic                      busy,
  output logic                      SLVSEL,
  output logic                      SCLK,
  output logic                      MOSI,
  input  logic                      MISO
);

  localparam int unsigned DivW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HalfW = $clog2(2 * DATA_W);

  typedef enum logic [2:0] {StIdle, StSetup, StShift, StHold, StDone} state_e;

  state_e              state_q, state_d;
  logic [DivW-1:0]     div_q, div_d;
  logic [HalfW-1:0]    half_q, half_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [IdW-1:0]      id_q, id_d;
`ifndef SPI_MASTER_SCHED_FIXED_PRIO_EN
  logic [IdW-1:0]      ptr_q, ptr_d;
  logic [IdW:0]        ptr_nxt;
`endif

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IdW:0]         base;
  logic [IdW:0]         grant_sum;
  logic [IdW-1:0]       grant_idx;
  logic                 grant_any;
  logic                 grant_fire;
  logic                 div_last;
  logic                 half_last;

  assign div_last   = (div_q == DivW'(CLK_DIV - 1));
  assign half_last  = (half_q == HalfW'(2 * DATA_W - 1));
  assign grant_fire = (state_q == StIdle) && grant_any && !rst;

  // Arbiter: rotate requests so the search starts at the pointer, then map back.
  always_comb begin
    req_dbl = {req_valid, req_valid};
`ifdef SPI_MASTER_SCHED_FIXED_PRIO_EN
    base = '0;
`else
    base = {1'b0, ptr_q};
`endif
    req_rot   = NUM_REQ'(req_dbl >> base);
    grant_any = 1'b0;
    grant_sum = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!grant_any && req_rot[i]) begin
        grant_any = 1'b1;
        grant_sum = base + (IdW + 1)'(i);
      end
    end
    if (grant_sum >= (IdW + 1)'(NUM_REQ)) begin
      grant_sum = grant_sum - (IdW + 1)'(NUM_REQ);
    end
    grant_idx = grant_sum[IdW-1:0];
  end

  // State register and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      div_q      <= '0;
      half_q     <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rsp_data_q <= '0;
      id_q       <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      half_q     <= half_d;
      tx_q       <= tx_d;
      rx_q       <= rx_d;
      rsp_data_q <= rsp_data_d;
      id_q       <= id_d;
    end
  end

`ifndef SPI_MASTER_SCHED_FIXED_PRIO_EN
  // Round-robin pointer: one past the last granted requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Pointer next-state, wrapping at NUM_REQ.
  always_comb begin
    ptr_d   = ptr_q;
    ptr_nxt = {1'b0, grant_idx} + (IdW + 1)'(1);
    if (ptr_nxt >= (IdW + 1)'(NUM_REQ)) begin
      ptr_nxt = '0;
    end
    if (grant_fire) begin
      ptr_d = ptr_nxt[IdW-1:0];
    end
  end
`endif

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_fire) state_d = StSetup;
      StSetup: if (div_last) state_d = StShift;
      StShift: if (div_last && half_last) state_d = StHold;
      StHold:  if (div_last) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Divider, half-period counter and shift registers.
  // Even half-periods of SHIFT have SCLK high; a rise is the entry into an even
  // half, a fall is the entry into an odd half.
  always_comb begin
    div_d      = '0;
    half_d     = half_q;
    tx_d       = tx_q;
    rx_d       = rx_q;
    rsp_data_d = rsp_data_q;
    id_d       = id_q;
    if (state_q == StSetup || state_q == StShift || state_q == StHold) begin
      div_d = div_last ? '0 : div_q + DivW'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (grant_fire) begin
          tx_d = req_data[grant_idx*DATA_W +: DATA_W];
          rx_d = '0;
          id_d = grant_idx;
        end
      end
      StSetup: begin
        half_d = '0;
        if (div_last) rx_d = {rx_q[DATA_W-2:0], MISO};
      end
      StShift: begin
        if (div_last) begin
          half_d = half_q + HalfW'(1);
          if (half_q[0] && !half_last) begin
            rx_d = {rx_q[DATA_W-2:0], MISO};
          end
          if (!half_q[0] && half_q != HalfW'(2 * DATA_W - 2)) begin
            tx_d = {tx_q[DATA_W-2:0], 1'b0};
          end
        end
      end
      StHold: begin
        if (div_last) rsp_data_d = rx_q;
      end
      StDone: ;
      default: ;
    endcase
  end

  // Output decode from state.
  always_comb begin
    SLVSEL    = 1'b1;
    SCLK      = 1'b0;
    MOSI      = 1'b0;
    rsp_valid = 1'b0;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_fire) req_ready = NUM_REQ'(1) << grant_idx;
      end
      StSetup: begin
        SLVSEL = 1'b0;
        MOSI   = tx_q[DATA_W-1];
      end
      StShift: begin
        SLVSEL = 1'b0;
        SCLK   = ~half_q[0];
        MOSI   = tx_q[DATA_W-1];
      end
      StHold: begin
        SLVSEL = 1'b0;
        MOSI   = tx_q[DATA_W-1];
      end
      StDone:  rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign busy     = (state_q != StIdle);
  assign rsp_data = rsp_data_q;
  assign rsp_id   = id_q;

endmodule

// File: tb/tb_spi_master_sched.sv
// Directed bench for spi_master_sched: a 2-requester/CLK_DIV=4 instance and a
// 1-requester/CLK_DIV=1 instance, with a simple mode-0 slave model.
module tb_spi_master_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  req_valid;
  logic [15:0] req_data;
  logic [1:0]  req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [0:0]  rsp_id;
  logic        busy, ss, sclk, mosi, miso;

  logic [0:0]  d1_valid;
  logic [7:0]  d1_data;
  logic [0:0]  d1_ready;
  logic        d1_rsp_valid;
  logic [7:0]  d1_rsp_data;
  logic [0:0]  d1_rsp_id;
  logic        d1_busy, d1_ss, d1_sclk, d1_mosi;
  logic        d1_miso;
  assign d1_miso = 1'b0;

  spi_master_sched #(.NUM_REQ(2), .DATA_W(8), .CLK_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_id(rsp_id), .busy(busy), .SLVSEL(ss), .SCLK(sclk), .MOSI(mosi), .MISO(miso)
  );

  spi_master_sched #(.NUM_REQ(1), .DATA_W(8), .CLK_DIV(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(d1_valid), .req_data(d1_data),
    .req_ready(d1_ready), .rsp_valid(d1_rsp_valid), .rsp_data(d1_rsp_data),
    .rsp_id(d1_rsp_id), .busy(d1_busy), .SLVSEL(d1_ss), .SCLK(d1_sclk), .MOSI(d1_mosi),
    .MISO(d1_miso)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor / slave state for u_dut
  logic [7:0] slave_tx    = 8'h00;
  logic [7:0] mosi_bits   = 8'h00;
  int         fall_cnt    = 0;
  int         rise_cnt    = 0;
  int         last_rise   = -1;
  int         per_min     = 1000;
  int         per_max     = 0;
  int         lo_cur      = 0;
  int         hi_cur      = 0;
  int         ss_last_low = 0;
  int         gap_last    = 0;
  int         rsp_cnt     = 0;
  int         rsp_long    = 0;
  int         ready_long  = 0;
  logic       prev_ss     = 1'b1;
  logic       prev_sclk   = 1'b0;
  logic       prev_rsp    = 1'b0;
  logic [1:0] prev_ready  = 2'b00;

  // Samples u_dut a few ns after each falling clk edge and plays the slave.
  initial begin
    miso = 1'b0;
    forever begin
      @(negedge clk);
      #3;
      if (prev_ss && !ss) begin
        gap_last  = hi_cur;
        lo_cur    = 0;
        rise_cnt  = 0;
        mosi_bits = 8'h00;
        last_rise = -1;
        per_min   = 1000;
        per_max   = 0;
      end
      if (!prev_ss && ss) begin
        ss_last_low = lo_cur;
        hi_cur      = 0;
      end
      if (ss) hi_cur++;
      else lo_cur++;
      if (sclk && !prev_sclk) begin
        rise_cnt++;
        mosi_bits = {mosi_bits[6:0], mosi};
        if (last_rise >= 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
      end
      if (ss) fall_cnt = 0;
      else if (!sclk && prev_sclk) fall_cnt++;
      miso = (fall_cnt < 8) ? slave_tx[7-fall_cnt] : 1'b0;
      if (rsp_valid) rsp_cnt++;
      if (rsp_valid && prev_rsp) rsp_long++;
      if (req_ready != 2'b00 && prev_ready != 2'b00) ready_long++;
      prev_ss    = ss;
      prev_sclk  = sclk;
      prev_rsp   = rsp_valid;
      prev_ready = req_ready;
    end
  end

  logic exp_ptr = 1'b0;

  function automatic logic [1:0] model_grant(input logic [1:0] vld);
`ifdef SPI_MASTER_SCHED_FIXED_PRIO_EN
    if (vld[0]) return 2'b01;
    if (vld[1]) return 2'b10;
    return 2'b00;
`else
    if (vld[exp_ptr]) return exp_ptr ? 2'b10 : 2'b01;
    return exp_ptr ? 2'b01 : 2'b10;
`endif
  endfunction

  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int n = 0; n < 50; n++) begin
      #1;
      if (req_ready != 2'b00) begin
        g = req_ready;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (rsp_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  // One full frame on u_dut; exp_gap > 0 also checks the SLVSEL-high gap before it.
  task automatic do_frame(input logic [1:0] vld, input logic [15:0] dat, input logic [7:0] stx,
                          input bit keep, input int exp_gap);
    logic [1:0] g, eg;
    logic [7:0] etx;
    int         gc;
    bit         ok;
    eg       = model_grant(vld);
    etx      = eg[1] ? dat[15:8] : dat[7:0];
    slave_tx = stx;
    req_data = dat;
    req_valid = vld;
    wait_grant(g);
    gc = cyc;
    check("grant", 32'(g), 32'(eg));
    exp_ptr = eg[0];
    @(negedge clk);
    if (!keep) req_valid = 2'b00;
    #1;
    check("ready_pulse", 32'(req_ready), 32'd0);
    check("busy_frame", 32'(busy), 32'd1);
    wait_rsp(ok);
    check("rsp_seen", 32'(ok), 32'd1);
    check("latency", cyc - gc, 32'd73);
    check("rsp_data", 32'(rsp_data), 32'(stx));
    check("rsp_id", 32'(rsp_id), 32'(eg[1]));
    check("busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    #1;
    check("busy_after", 32'(busy), 32'd0);
    check("mosi_bits", 32'(mosi_bits), 32'(etx));
    check("ss_low", ss_last_low, 32'd72);
    check("sclk_rises", rise_cnt, 32'd8);
    check("sclk_per_min", per_min, 32'd8);
    check("sclk_per_max", per_max, 32'd8);
    if (exp_gap > 0) check("ss_gap", gap_last, exp_gap);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] g;
    logic [7:0] bits;
    int         gc, r0, rises, last, pmin, pmax;
    bit         got;
    logic       prev;

    rst = 1'b1;
    req_valid = 2'b00;
    req_data = 16'h0000;
    d1_valid = 1'b0;
    d1_data = 8'hFF;
    repeat (3) @(negedge clk);
    #1;
    check("rst_ss", 32'(ss), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_d1_ss", 32'(d1_ss), 32'd1);
    rst = 1'b0;
    @(negedge clk);

    // Contention: both held valid for four frames.
    for (int i = 0; i < 4; i++) begin
      do_frame(2'b11, 16'hF00F, 8'h81 + 8'(i * 17), (i < 3), (i == 0) ? 0 : 2);
    end

    // Single frame from req0.
    repeat (3) @(negedge clk);
    do_frame(2'b01, 16'h00A5, 8'h3C, 1'b0, 0);

    // Pointer wrap: req1 alone, then both.
    repeat (3) @(negedge clk);
    do_frame(2'b10, 16'h9600, 8'h5A, 1'b0, 0);
    repeat (2) @(negedge clk);
    do_frame(2'b11, 16'h69A5, 8'hC3, 1'b0, 0);

    // Reset after the 3rd SCLK rise of a req0 frame.
    repeat (3) @(negedge clk);
    slave_tx = 8'hE7;
    req_data = 16'h0077;
    req_valid = 2'b01;
    wait_grant(g);
    check("rst_test_grant", 32'(g), 32'(model_grant(2'b01)));
    @(negedge clk);
    req_valid = 2'b00;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #4;
      if (rise_cnt >= 3) break;
    end
    check("rst_test_rises", rise_cnt, 32'd3);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_ss", 32'(ss), 32'd1);
    check("midrst_sclk", 32'(sclk), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    r0 = rsp_cnt;
    repeat (100) @(negedge clk);
    check("midrst_no_rsp", rsp_cnt - r0, 32'd0);
    exp_ptr = 1'b0;
    do_frame(2'b11, 16'h1E2D, 8'h4B, 1'b0, 0);

    // CLK_DIV=1 instance: TX=0xFF, MISO tied low.
    repeat (2) @(negedge clk);
    d1_valid = 1'b1;
    #1;
    check("d1_ready", 32'(d1_ready), 32'd1);
    gc = cyc;
    @(negedge clk);
    d1_valid = 1'b0;
    prev = 1'b0; rises = 0; bits = 8'h00; last = -1; pmin = 1000; pmax = 0; got = 1'b0;
    for (int n = 0; n < 60; n++) begin
      #1;
      if (d1_sclk && !prev) begin
        rises++;
        bits = {bits[6:0], d1_mosi};
        if (last >= 0) begin
          if (cyc - last < pmin) pmin = cyc - last;
          if (cyc - last > pmax) pmax = cyc - last;
        end
        last = cyc;
      end
      prev = d1_sclk;
      if (d1_rsp_valid) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("d1_rsp_seen", 32'(got), 32'd1);
    check("d1_latency", cyc - gc, 32'd19);
    check("d1_rsp_data", 32'(d1_rsp_data), 32'h00);
    check("d1_rsp_id", 32'(d1_rsp_id), 32'd0);
    check("d1_mosi_bits", 32'(bits), 32'hFF);
    check("d1_rises", rises, 32'd8);
    check("d1_per_min", pmin, 32'd2);
    check("d1_per_max", pmax, 32'd2);

    repeat (3) @(negedge clk);
    #5;
    check("rsp_count", rsp_cnt, 32'd8);
    check("rsp_1cycle", rsp_long, 32'd0);
    check("ready_1cycle", ready_long, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
